// File: rtl/ib_tx_arbiter.sv
// Two-source arbiter for the IB expander's 4-phase byte channel (tx_data / available / ack_n).
// Each accepted valid/ready byte becomes one full exchange; stalled exchanges are aborted by a watchdog.
module ib_tx_arbiter #(
    parameter bit FAIR           = 1'b1,
    parameter int TIMEOUT_CYCLES = 737280,
    parameter int TW             = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    output logic       s1_ready,
    output logic [7:0] m_data,
    output logic       m_available,
    input  logic       m_ack_n,
    output logic       busy,
    output logic       grant_id,
    output logic       timeout_err,
    output logic [7:0] drop_cnt,
    input  logic       clr_err
);

    typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;

    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t          state_reg, state_next;
    logic [7:0]      m_data_reg, m_data_next;
    logic            m_available_reg, m_available_next;
    logic            grant_id_reg, grant_id_next;
    logic            last_reg, last_next;
    logic [TW-1:0]   wdog_reg, wdog_next;
    logic            timeout_err_reg, timeout_err_next;
    logic [7:0]      drop_cnt_reg, drop_cnt_next;

    logic [1:0]      src_valid;
    logic [7:0]      src_data [2];
    logic [1:0]      src_ready;
    logic            sel;
    logic            can_grant;
    logic            xfer;
    logic            abort;

    assign src_valid   = {s1_valid, s0_valid};
    assign src_data[0] = s0_data;
    assign src_data[1] = s1_data;

    // On contention the fair mode hands the channel to whichever source did not go last.
    always_comb begin
        if (s0_valid && s1_valid) begin
            sel = FAIR ? ~last_reg : 1'b0;
        end else begin
            sel = s1_valid;
        end
    end

    // A stale ack from the previous exchange blocks new grants until the expander releases it.
    assign can_grant = (state_reg == IDLE) && m_ack_n;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign src_ready[gi] = can_grant && src_valid[gi] && (sel == 1'(gi));
        end
    endgenerate

    assign s0_ready = src_ready[0];
    assign s1_ready = src_ready[1];
    assign xfer     = |src_ready;

    always_comb begin
        state_next       = state_reg;
        m_data_next      = m_data_reg;
        m_available_next = m_available_reg;
        grant_id_next    = grant_id_reg;
        last_next        = last_reg;
        wdog_next        = wdog_reg;
        abort            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    m_data_next      = src_data[sel];
                    grant_id_next    = sel;
                    last_next        = sel;
                    m_available_next = 1'b1;
                    wdog_next        = '0;
                    state_next       = PRESENT;
                end
            end
            PRESENT: begin
                if (!m_ack_n) begin
                    m_available_next = 1'b0;
                    wdog_next        = '0;
                    state_next       = RELEASE;
                end else if (wdog_reg == WD_LAST) begin
                    m_available_next = 1'b0;
                    wdog_next        = '0;
                    abort            = 1'b1;
                    state_next       = RELEASE;
                end else begin
                    wdog_next = wdog_reg + TW'(1);
                end
            end
            RELEASE: begin
                if (m_ack_n) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next       = IDLE;
                m_available_next = 1'b0;
            end
        endcase
    end

    // An abort in the same cycle as a clear leaves exactly one drop recorded.
    always_comb begin
        timeout_err_next = timeout_err_reg;
        drop_cnt_next    = drop_cnt_reg;
        if (abort) begin
            timeout_err_next = 1'b1;
            if (clr_err) begin
                drop_cnt_next = 8'd1;
            end else if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_next = drop_cnt_reg + 8'd1;
            end
        end else if (clr_err) begin
            timeout_err_next = 1'b0;
            drop_cnt_next    = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            m_data_reg      <= 8'd0;
            m_available_reg <= 1'b0;
            grant_id_reg    <= 1'b0;
            last_reg        <= 1'b1;
            wdog_reg        <= '0;
            timeout_err_reg <= 1'b0;
            drop_cnt_reg    <= 8'd0;
        end else begin
            state_reg       <= state_next;
            m_data_reg      <= m_data_next;
            m_available_reg <= m_available_next;
            grant_id_reg    <= grant_id_next;
            last_reg        <= last_next;
            wdog_reg        <= wdog_next;
            timeout_err_reg <= timeout_err_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    assign m_data      = m_data_reg;
    assign m_available = m_available_reg;
    assign grant_id    = grant_id_reg;
    assign timeout_err = timeout_err_reg;
    assign drop_cnt    = drop_cnt_reg;
    assign busy        = (state_reg != IDLE);

endmodule
